// File: rtl/filter_out_writer_240px_if.sv
// 16-bit memory-mapped write bus between the filter output writer and the frame buffer.
interface filter_out_writer_240px_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] m_address;
  logic [15:0]       m_writedata;
  logic              m_write;
  logic              m_waitrequest;

  modport master (output m_address, m_writedata, m_write, input m_waitrequest);
  modport slave  (input m_address, m_writedata, m_write, output m_waitrequest);
endinterface

// File: rtl/filter_out_writer_240px.sv
// Buffers filtered RGB565 pixels in a small FIFO and writes them to the frame buffer.
// Optional stall counter output enabled by defining FILTER_OUT_STALL_CNT_EN.
module filter_out_writer_240px #(
  parameter int BLOCK_LENGTH = 240,
  parameter int BLOCK_ROWS   = 240,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [15:0]               d_in,
  input  logic                      d_valid,
  output logic                      in_ready,
  output logic [9:0]                cursor,
  output logic [8:0]                row,
  filter_out_writer_240px_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef FILTER_OUT_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TOTAL = BLOCK_LENGTH * BLOCK_ROWS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [15:0]        fifo_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  base_reg;
  logic [16:0]        write_index_reg;
  logic [16:0]        pix_count_reg;
  logic [9:0]         cursor_reg;
  logic [8:0]         row_reg;
  logic               overflow_reg;

  logic               active;
  logic               push;
  logic               pop;
  logic               write_req;

  assign active    = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign in_ready  = (state_reg == S_RUN) && (count_reg < CNT_W'(FIFO_DEPTH));
  assign push      = d_valid && in_ready;
  assign write_req = active && (count_reg != '0);
  assign pop       = write_req && !bus.m_waitrequest;

  assign bus.m_write     = write_req;
  assign bus.m_writedata = write_req ? fifo_mem[rd_ptr_reg] : 16'h0000;
  // Address only moves on a completed write, so it is stable across a stall.
  assign bus.m_address   = base_reg + (ADDR_W'(write_index_reg) << 1);

  assign cursor   = cursor_reg;
  assign row      = row_reg;
  assign overflow = overflow_reg;
  assign busy     = active;
  assign done     = (state_reg == S_DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      base_reg        <= '0;
      write_index_reg <= '0;
      pix_count_reg   <= '0;
      cursor_reg      <= '0;
      row_reg         <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg    <= wr_ptr_reg + PTR_W'(1);
        pix_count_reg <= pix_count_reg + 17'd1;
        if (cursor_reg == 10'(BLOCK_LENGTH - 1)) begin
          cursor_reg <= '0;
          row_reg    <= row_reg + 9'd1;
        end else begin
          cursor_reg <= cursor_reg + 10'd1;
        end
      end

      if (pop) begin
        rd_ptr_reg      <= rd_ptr_reg + PTR_W'(1);
        write_index_reg <= write_index_reg + 17'd1;
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: ;
      endcase

      // A pixel offered while the FIFO is full is lost; only flag it mid-frame.
      if ((state_reg == S_RUN) && d_valid && !in_ready) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg       <= S_RUN;
            base_reg        <= base_addr;
            overflow_reg    <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            write_index_reg <= '0;
            pix_count_reg   <= '0;
            cursor_reg      <= '0;
            row_reg         <= '0;
          end
        end
        S_RUN: begin
          if (push && (pix_count_reg == 17'(TOTAL - 1))) begin
            state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_reg == '0) begin
            state_reg <= S_DONE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef FILTER_OUT_STALL_CNT_EN
  logic [31:0] stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_reg <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      stall_reg <= '0;
    end else if (write_req && bus.m_waitrequest && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_filter_out_writer_240px.sv
// Self-checking bench for filter_out_writer_240px: vector table, directed corner cases,
// and randomized frames against a queue-based reference model.
module tb_filter_out_writer_240px;

  localparam int BL    = 4;
  localparam int BR    = 2;
  localparam int DEPTH = 8;
  localparam int TOTAL = BL * BR;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] d_in;
  logic        d_valid;
  logic        in_ready;
  logic [9:0]  cursor;
  logic [8:0]  row;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] stall_cycles;

  filter_out_writer_240px_if #(.ADDR_W(32)) bus ();

  filter_out_writer_240px #(
    .BLOCK_LENGTH(BL), .BLOCK_ROWS(BR), .FIFO_DEPTH(DEPTH), .ADDR_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .d_in(d_in), .d_valid(d_valid), .in_ready(in_ready),
    .cursor(cursor), .row(row), .bus(bus),
    .busy(busy), .done(done), .overflow(overflow)
`ifdef FILTER_OUT_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // Second instance with a 16-pixel frame so the FIFO can fill while still in RUN.
  logic        b_start;
  logic [31:0] b_base;
  logic [15:0] b_din;
  logic        b_dv;
  logic        b_in_ready;
  logic [9:0]  b_cursor;
  logic [8:0]  b_row;
  logic        b_busy;
  logic        b_done;
  logic        b_ovf;
  logic [31:0] b_stall;

  filter_out_writer_240px_if #(.ADDR_W(32)) bus_b ();

  filter_out_writer_240px #(
    .BLOCK_LENGTH(4), .BLOCK_ROWS(4), .FIFO_DEPTH(8), .ADDR_W(32)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .base_addr(b_base),
    .d_in(b_din), .d_valid(b_dv), .in_ready(b_in_ready),
    .cursor(b_cursor), .row(b_row), .bus(bus_b),
    .busy(b_busy), .done(b_done), .overflow(b_ovf)
`ifdef FILTER_OUT_STALL_CNT_EN
    , .stall_cycles(b_stall)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, a queue of buffered pixels, and running counts.
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_t;
  mphase_t     ms = M_IDLE;
  logic [15:0] mq[$];
  int          acc = 0;
  int          wrn = 0;
  logic [31:0] mbase = 0;
  bit          movf = 0;
  logic [31:0] mstall = 0;

  task automatic model_edge();
    int n;
    bit run, act, can, pushing, popping;
    n       = mq.size();
    run     = (ms == M_RUN);
    act     = (ms == M_RUN) || (ms == M_DRAIN);
    can     = run && (n < DEPTH);
    pushing = d_valid && can;
    popping = act && (n > 0) && !bus.m_waitrequest;
    if (reset) begin
      ms = M_IDLE; mq.delete(); acc = 0; wrn = 0; mbase = 0; movf = 0; mstall = 0;
      return;
    end
    if (act && (n > 0) && bus.m_waitrequest && (mstall != 32'hFFFF_FFFF)) mstall++;
    if (run && d_valid && !can) movf = 1;
    case (ms)
      M_IDLE:  if (start) begin
                 ms = M_RUN; mbase = base_addr; movf = 0; acc = 0; wrn = 0;
                 mq.delete(); mstall = 0;
               end
      M_RUN:   if (pushing && (acc == TOTAL - 1)) ms = M_DRAIN;
      M_DRAIN: if (n == 0) ms = M_DONE;
      default: ms = M_IDLE;
    endcase
    if (popping) begin
      void'(mq.pop_front());
      wrn++;
    end
    if (pushing) begin
      mq.push_back(d_in);
      acc++;
    end
  endtask

  task automatic compare_all();
    int n;
    bit act;
    n   = mq.size();
    act = (ms == M_RUN) || (ms == M_DRAIN);
    check("in_ready",  32'(in_ready),     32'((ms == M_RUN) && (n < DEPTH)));
    check("cursor",    32'(cursor),       32'(acc % BL));
    check("row",       32'(row),          32'(acc / BL));
    check("m_write",   32'(bus.m_write),  32'(act && (n > 0)));
    check("m_address", bus.m_address,     mbase + 32'(2 * wrn));
    if (act && (n > 0)) check("m_writedata", 32'(bus.m_writedata), 32'(mq[0]));
    check("busy",      32'(busy),         32'(act));
    check("done",      32'(done),         32'(ms == M_DONE));
    check("overflow",  32'(overflow),     32'(movf));
`ifdef FILTER_OUT_STALL_CNT_EN
    check("stall_cycles", stall_cycles, mstall);
`endif
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
  task automatic step(input bit st, input logic [31:0] ba, input bit dv,
                      input logic [15:0] din, input bit wr);
    start = st; base_addr = ba; d_valid = dv; d_in = din; bus.m_waitrequest = wr;
    if (bus.m_write && !wr)
      $display("write addr=0x%08h data=0x%04h", bus.m_address, bus.m_writedata);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  logic [15:0] pix = 16'h0a00;

  task automatic finish_frame(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (ms == M_IDLE) break;
      step(1'b0, 32'h0, (ms == M_RUN), pix, 1'b0);
      pix = pix + 16'd1;
    end
    check("frame_end_busy", 32'(busy), 32'h0);
  endtask

  task automatic tick_b();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          st;
    bit          dv;
    logic [15:0] din;
    int          e_cursor;
    int          e_row;
    bit          e_mw;
    logic [31:0] e_addr;
    logic [15:0] e_data;
    bit          e_busy;
    bit          e_done;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0] = '{1, 0, 16'h0, 0, 0, 0, 32'h1000, 16'h0, 1, 0};
    for (int k = 1; k <= 8; k++)
      vt[k] = '{0, 1, 16'(k), k % 4, k / 4, 1, 32'h1000 + 32'(2 * (k - 1)), 16'(k), 1, 0};
    vt[9]  = '{0, 0, 16'h0, 0, 2, 0, 32'h1010, 16'h0, 1, 0};
    vt[10] = '{0, 0, 16'h0, 0, 2, 0, 32'h1010, 16'h0, 0, 1};
    vt[11] = '{0, 0, 16'h0, 0, 2, 0, 32'h1010, 16'h0, 0, 0};

    reset = 1'b1; start = 1'b0; base_addr = '0; d_in = '0; d_valid = 1'b0;
    bus.m_waitrequest = 1'b0;
    b_start = 1'b0; b_base = '0; b_din = '0; b_dv = 1'b0; bus_b.m_waitrequest = 1'b0;
    @(negedge clk);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset = 1'b0;
    check("rst_m_writedata", 32'(bus.m_writedata), 32'h0);
    check("rst_m_address",   bus.m_address,        32'h0);
    check("rst_b_busy",      32'(b_busy),          32'h0);

    // Back-to-back frame against the vector table.
    for (int i = 0; i < 12; i++) begin
      step(vt[i].st, 32'h1000, vt[i].dv, vt[i].din, 1'b0);
      check($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vt[i].e_cursor));
      check($sformatf("vec%0d_row", i),    32'(row),    32'(vt[i].e_row));
      check($sformatf("vec%0d_mwrite", i), 32'(bus.m_write), 32'(vt[i].e_mw));
      check($sformatf("vec%0d_addr", i),   bus.m_address, vt[i].e_addr);
      if (vt[i].e_mw) check($sformatf("vec%0d_data", i), 32'(bus.m_writedata), 32'(vt[i].e_data));
      check($sformatf("vec%0d_busy", i),   32'(busy), 32'(vt[i].e_busy));
      check($sformatf("vec%0d_done", i),   32'(done), 32'(vt[i].e_done));
    end

    // Waitrequest held for 20 cycles: FIFO fills, bus holds, then drains in order.
    step(1, 32'h2000, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 32'h0, 1, 16'h0100 + 16'(i), 1);
    check("stall_in_ready", 32'(in_ready),          32'h0);
    check("stall_addr",     bus.m_address,          32'h2000);
    check("stall_data",     32'(bus.m_writedata),   32'h0100);
    check("stall_no_ovf",   32'(overflow),          32'h0);
    finish_frame(40);

    // Five stalled cycles on a single queued pixel.
    step(1, 32'h2800, 0, 0, 0);
    step(0, 32'h0, 1, 16'h5a5a, 1);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0, 1);
`ifdef FILTER_OUT_STALL_CNT_EN
    check("stall_cycles_5", stall_cycles, 32'd5);
`endif
    check("stall_hold_data", 32'(bus.m_writedata), 32'h5a5a);
    finish_frame(40);

    // Reset mid-frame with three pixels queued.
    step(1, 32'h3000, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 16'h0300 + 16'(i), 1);
    reset = 1'b1;
    step(0, 32'h0, 0, 0, 1);
    reset = 1'b0;
    check("midrst_mwrite", 32'(bus.m_write), 32'h0);
    check("midrst_busy",   32'(busy),        32'h0);
    check("midrst_cursor", 32'(cursor),      32'h0);
    check("midrst_row",    32'(row),         32'h0);
    step(1, 32'h3400, 0, 0, 0);
    step(0, 32'h0, 1, 16'h0777, 0);
    check("fresh_addr", bus.m_address,        32'h3400);
    check("fresh_data", 32'(bus.m_writedata), 32'h0777);
    finish_frame(40);

    // d_valid in IDLE and start during RUN are both ignored.
    step(0, 32'h0, 1, 16'hbeef, 0);
    check("idle_dv_cursor", 32'(cursor),      32'h0);
    check("idle_dv_row",    32'(row),         32'h2);
    check("idle_dv_mwrite", 32'(bus.m_write), 32'h0);
    step(1, 32'h4000, 0, 0, 0);
    step(0, 32'h0, 1, 16'h0401, 1);
    step(0, 32'h0, 1, 16'h0402, 1);
    step(1, 32'h5000, 0, 0, 1);
    check("run_start_busy", 32'(busy),   32'h1);
    check("run_start_addr", bus.m_address, 32'h4000);
    check("run_start_cursor", 32'(cursor), 32'h2);
    finish_frame(40);

    // Randomized frames, including a base near the top of the address space.
    for (int f = 0; f < 4; f++) begin
      logic [31:0] b;
      b = (f == 3) ? 32'hFFFF_FFF8 : {$urandom_range(0, 32'hFFFF), 16'h0} + 32'(2 * f);
      step(1, b, 0, 0, 0);
      for (int i = 0; i < 500; i++) begin
        if (ms == M_IDLE) break;
        step(($urandom_range(0, 15) == 0), $urandom,
             $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) == 0);
      end
      check("rand_frame_idle", 32'(busy), 32'h0);
    end

    // Overflow while still in RUN on the 16-pixel instance.
    b_start = 1'b1; b_base = 32'h6000; tick_b(); b_start = 1'b0;
    bus_b.m_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_dv = 1'b1; b_din = 16'h0600 + 16'(i); tick_b();
    end
    check("b_full_in_ready", 32'(b_in_ready),          32'h0);
    check("b_full_cursor",   32'(b_cursor),            32'h0);
    check("b_full_row",      32'(b_row),               32'h2);
    check("b_full_ovf",      32'(b_ovf),               32'h0);
    check("b_full_addr",     bus_b.m_address,          32'h6000);
    check("b_full_data",     32'(bus_b.m_writedata),   32'h0600);
    b_din = 16'hdead; tick_b();
    check("b_ovf_set",       32'(b_ovf),     32'h1);
    check("b_ovf_cursor",    32'(b_cursor),  32'h0);
    check("b_ovf_row",       32'(b_row),     32'h2);
    bus_b.m_waitrequest = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
        b_dv = 1'b1; b_din = 16'h0700 + 16'(i); tick_b();
        if (b_done) begin
          saw_done = 1'b1;
          break;
        end
      end
      check("b_done_seen", 32'(saw_done), 32'h1);
    end
    b_dv = 1'b0;
    tick_b();
    b_start = 1'b1; b_base = 32'h7000; tick_b(); b_start = 1'b0;
    check("b_start_clears_ovf", 32'(b_ovf),      32'h0);
    check("b_restart_busy",     32'(b_busy),     32'h1);
    check("b_restart_addr",     bus_b.m_address, 32'h7000);
    check("b_restart_cursor",   32'(b_cursor),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_out_writer_240px.md
Name: filter_out_writer_240px

Overview:
- Downstream stage of the 3x3 filter.
- Accepts filtered RGB565 pixels on the filter's d_out/d_rdy strobe and buffers them in a small FIFO.
- Writes the pixels to the output frame buffer through a 16-bit memory-mapped master with waitrequest.
- Produces the cursor (pixel column within the current row) that the filter and the custom master synchronise against, and signals frame completion.

Parameters:
BLOCK_LENGTH, 240, pixels per row; cursor wraps at this count
BLOCK_ROWS, 240, rows per frame
FIFO_DEPTH, 8, entries in the pixel FIFO (power of 2, >=2)
ADDR_W, 32, master address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
base_addr  in  ADDR_W  byte address of pixel 0; latched on accepted start
d_in  in  16  filtered pixel (filter d_out)
d_valid  in  1  pixel strobe (filter d_rdy)
in_ready  out  1  FIFO can accept d_in this cycle
cursor  out  10  column of the next pixel to accept, 0..BLOCK_LENGTH-1
row  out  9  row of the next pixel to accept
m_address  out  ADDR_W  master byte address
m_writedata  out  16  master write data
m_write  out  1  master write request
m_waitrequest  in  1  slave stall
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at frame completion
overflow  out  1  sticky; d_valid arrived while in_ready was low in RUN

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, all counters 0. A reset mid-frame discards FIFO contents and drops m_write at that edge, with no completion of the outstanding write.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Latches base_addr, clears overflow and all counters.
  - RUN -> DRAIN on the edge that accepts pixel number BLOCK_LENGTH*BLOCK_ROWS-1.
  - DRAIN -> DONE when the FIFO is empty and no write is pending.
  - DONE -> IDLE after exactly one cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
- in_ready = (state==RUN) && (fifo_count < FIFO_DEPTH). This is combinational from registered state.
- Push occurs when d_valid && in_ready. Each push:
  - increments cursor;
  - when cursor==BLOCK_LENGTH-1, cursor wraps to 0 and row increments.
- d_valid with in_ready low:
  - in RUN: pixel dropped, overflow set, cursor unchanged;
  - in IDLE, DRAIN or DONE: ignored, no flag.
- Master handshake:
  - m_write is high whenever the FIFO is non-empty, in RUN or DRAIN.
  - m_writedata = FIFO head; m_address = base + 2*write_index.
  - Address and data are held stable while m_write && m_waitrequest.
  - Pop and write_index++ on m_write && !m_waitrequest.
- Latency: a pixel pushed at edge N is presented with m_write=1 from cycle N+1 if the FIFO was empty.
- Throughput is 1 pixel/cycle with waitrequest low.
- Simultaneous push and pop: fifo_count unchanged. This is legal when full, because in_ready already reflects full, so no push occurs when full.
- Write and address arithmetic:
  - write_index is 17 bits;
  - the address sum wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: FILTER_OUT_STALL_CNT_EN.
- When defined:
  - adds output stall_cycles [31:0];
  - counts cycles in RUN/DRAIN with m_write && m_waitrequest;
  - cleared on reset and on accepted start; saturates at 0xFFFFFFFF.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- BLOCK_LENGTH=4, BLOCK_ROWS=2, base_addr=0x1000, start, then 8 back-to-back pixels 0x0001..0x0008 with waitrequest=0.
  - Writes go to 0x1000,0x1002,...,0x100E with matching data.
  - cursor sequence is 1,2,3,0,1,2,3,0 and row ends at 2.
  - done pulses once, and busy drops the same cycle.
- Same setup with m_waitrequest held high for 20 cycles.
  - FIFO fills to 8 and in_ready goes low.
  - m_address/m_writedata stay stable; after release, all 8 pixels are written in order with no loss.
- d_valid asserted while full (waitrequest high).
  - overflow=1 and cursor does not advance.
  - The next start clears overflow.
- Reset asserted in RUN with 3 pixels queued.
  - Next cycle: m_write=0, busy=0, cursor=0, row=0.
  - A fresh start writes from base_addr.
- start pulsed during RUN and d_valid pulsed in IDLE.
  - No state change, no write, base_addr not relatched.
- With FILTER_OUT_STALL_CNT_EN and waitrequest high for 5 stalled cycles: stall_cycles=5.
